// File: rtl/rv32i_instr_encoder_loader_if.sv
// Request / instruction-memory bus for rv32i_instr_encoder_loader.
//   req_*  : symbolic instruction request with valid/ready handshake
//   imem_* : one-cycle instruction-memory write port (byte address, word aligned)
// The master drives requests and observes writes; the slave (the encoder)
// accepts requests and drives the write port.
interface rv32i_instr_encoder_loader_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_last;
    logic [2:0]        req_class;
    logic [2:0]        req_funct3;
    logic              req_f7b5;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_last, req_class, req_funct3, req_f7b5,
               req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_last, req_class, req_funct3, req_f7b5,
               req_rd, req_rs1, req_rs2, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/rv32i_instr_encoder_loader.sv
// rv32i_instr_encoder_loader
// Packs symbolic RV32I instruction requests into 32-bit words, range-checks
// the immediates, and writes the words to consecutive imem addresses.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        one-cycle pulse opening a new load session (highest priority)
//   bus            request handshake + imem write port (slave side)
//   count_o        words written in the current session
//   done_o         session complete (level)
//   err_o          sticky illegal-request flag
//   err_code_o     0 none, 1 imm range, 2 imm alignment, 3 LUI low bits set
module rv32i_instr_encoder_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    rv32i_instr_encoder_loader_if.slave bus,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_RANGE = 2'd1;
    localparam logic [1:0] E_ALIGN = 2'd2;
    localparam logic [1:0] E_LUI   = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ENC, S_WRITE, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cls_q, f3_q;
    logic              f7b5_q, last_q;
    logic [4:0]        rd_q, rs1_q, rs2_q;
    logic [31:0]       imm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic [31:0]       enc_word;
    logic [1:0]        enc_err;
    logic [CNT_W-1:0]  count_inc;
    logic signed [31:0] imm_s;
    logic              is_shift, imm12_ok, shamt_ok, br_ok, jal_ok;

    assign count_inc = count_q + 1'b1;
    assign imm_s     = $signed(imm_q);
    assign is_shift  = (f3_q == 3'b001) || (f3_q == 3'b101);
    assign imm12_ok  = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
    // Unsigned compare also rejects every negative value.
    assign shamt_ok  = (imm_q < 32'd32);
    assign br_ok     = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094);
    assign jal_ok    = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);

    // Encoder and legality check on the latched request. Range is tested
    // before alignment so a value failing both reports a range error.
    always_comb begin
        enc_word = 32'h0;
        enc_err  = E_NONE;
        case (cls_q)
            3'd0: enc_word = {1'b0, f7b5_q, 5'b0, rs2_q, rs1_q, f3_q, rd_q, OPC_OP};
            3'd1: begin
                enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_LOAD};
                if (!imm12_ok) enc_err = E_RANGE;
            end
            3'd2: begin
                if (is_shift) begin
                    enc_word = {1'b0, f7b5_q, 5'b0, imm_q[4:0], rs1_q, f3_q, rd_q, OPC_IMM};
                    if (!shamt_ok) enc_err = E_RANGE;
                end else begin
                    enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_IMM};
                    if (!imm12_ok) enc_err = E_RANGE;
                end
            end
            3'd3: begin
                enc_word = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_JALR};
                if (!imm12_ok) enc_err = E_RANGE;
            end
            3'd4: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OPC_STORE};
                if (!imm12_ok) enc_err = E_RANGE;
            end
            3'd5: begin
                enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                            imm_q[4:1], imm_q[11], OPC_BRANCH};
                if (!br_ok)        enc_err = E_RANGE;
                else if (imm_q[0]) enc_err = E_ALIGN;
            end
            3'd6: begin
                enc_word = {imm_q[31:12], rd_q, OPC_LUI};
                if (imm_q[11:0] != 12'h0) enc_err = E_LUI;
            end
            default: begin
                enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OPC_JAL};
                if (!jal_ok)       enc_err = E_RANGE;
                else if (imm_q[0]) enc_err = E_ALIGN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake/strobe outputs. start overrides every state;
    // it also masks the write strobe so an in-flight word never lands.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.imem_we   = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            S_WAIT: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = S_ENC;
            end
            S_ENC:   state_d = (enc_err != E_NONE) ? S_DONE : S_WRITE;
            S_WRITE: begin
                bus.imem_we = !start_i;
                state_d     = (last_q || count_inc == DEPTH_C) ? S_DONE : S_WAIT;
            end
            S_DONE:  done_o = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (start_i) state_d = S_WAIT;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cls_q      <= '0;
            f3_q       <= '0;
            f7b5_q     <= 1'b0;
            last_q     <= 1'b0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
        end else if (start_i) begin
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
        end else begin
            case (state_q)
                S_WAIT: if (bus.req_valid) begin
                    cls_q  <= bus.req_class;
                    f3_q   <= bus.req_funct3;
                    f7b5_q <= bus.req_f7b5;
                    last_q <= bus.req_last;
                    rd_q   <= bus.req_rd;
                    rs1_q  <= bus.req_rs1;
                    rs2_q  <= bus.req_rs2;
                    imm_q  <= bus.req_imm;
                end
                S_ENC: begin
                    wdata_q    <= enc_word;
                    err_code_q <= enc_err;
                    if (enc_err != E_NONE) err_q <= 1'b1;
                end
                S_WRITE: begin
                    addr_q  <= addr_q + ADDR_W'(4);
                    count_q <= count_inc;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count_o        = count_q;
    assign err_o          = err_q;
    assign err_code_o     = err_code_q;
endmodule

// File: tb/tb_rv32i_instr_encoder_loader.sv
module tb_rv32i_instr_encoder_loader;
    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        last;
    } req_t;
    typedef struct { req_t r; logic [31:0] word; logic [1:0] code; } vec_t;
    typedef struct { logic [31:0] word; logic [1:0] code; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;

    logic clk = 1'b0;
    logic rst, start, req_valid, req_last, req_f7b5;
    logic [2:0] req_class, req_funct3;
    logic [4:0] req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic [8:0] count0;
    logic [2:0] count1;
    logic done0, err0, done1, err1;
    logic [1:0] code0, code1;

    always #5 clk = ~clk;

    rv32i_instr_encoder_loader_if #(.ADDR_W(32)) bus0 ();
    rv32i_instr_encoder_loader_if #(.ADDR_W(32)) bus1 ();

    assign bus0.req_valid = req_valid;   assign bus1.req_valid = req_valid;
    assign bus0.req_last = req_last;     assign bus1.req_last = req_last;
    assign bus0.req_class = req_class;   assign bus1.req_class = req_class;
    assign bus0.req_funct3 = req_funct3; assign bus1.req_funct3 = req_funct3;
    assign bus0.req_f7b5 = req_f7b5;     assign bus1.req_f7b5 = req_f7b5;
    assign bus0.req_rd = req_rd;         assign bus1.req_rd = req_rd;
    assign bus0.req_rs1 = req_rs1;       assign bus1.req_rs1 = req_rs1;
    assign bus0.req_rs2 = req_rs2;       assign bus1.req_rs2 = req_rs2;
    assign bus0.req_imm = req_imm;       assign bus1.req_imm = req_imm;

    rv32i_instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(256)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus0.slave),
        .count_o(count0), .done_o(done0), .err_o(err0), .err_code_o(code0));

    rv32i_instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus1.slave),
        .count_o(count1), .done_o(done1), .err_o(err1), .err_code_o(code1));

    int n_chk = 0, n_pass = 0, cyc = 0;
    wr_t wq0[$], wq1[$];
    int hs0[$], hs1[$];
    req_t sess[$];
    vec_t tab[$];
    int edges[18] = '{-2049, -2048, 2047, 2048, 4094, 4095, -4096, -4097, 32, 31,
                      -1, 1, 1048574, 1048576, -1048576, -1048578, 4096, 4097};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus0.imem_we) wq0.push_back('{bus0.imem_addr, bus0.imem_wdata, cyc});
        if (bus1.imem_we) wq1.push_back('{bus1.imem_addr, bus1.imem_wdata, cyc});
        if (req_valid && bus0.req_ready) hs0.push_back(cyc);
        if (req_valid && bus1.req_ready) hs1.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic req_t mk(input int cls, f3, f7b5, rd, rs1, rs2, input logic [31:0] imm,
                                input bit last);
        req_t r;
        r.cls = 3'(cls); r.f3 = 3'(f3); r.f7b5 = 1'(f7b5);
        r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm; r.last = last;
        return r;
    endfunction

    // Reference: field placement by shifts and masks, legality by integer ranges.
    function automatic exp_t model(input req_t r);
        exp_t e;
        int v = $signed(r.imm);
        logic [31:0] u = r.imm, rd = 32'(r.rd), s1 = 32'(r.rs1), s2 = 32'(r.rs2);
        logic [31:0] f3 = 32'(r.f3), f7 = 32'(r.f7b5);
        e.code = 2'd0;
        case (r.cls)
            3'd0: e.word = (f7 << 30) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            3'd1, 3'd3: begin
                e.word = ((u & 32'hFFF) << 20) | (s1 << 15) | (rd << 7)
                       | ((r.cls == 3'd1) ? ((f3 << 12) | 32'h03) : 32'h67);
                if (v < -2048 || v > 2047) e.code = 2'd1;
            end
            3'd2: if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
                e.word = (f7 << 30) | ((u & 31) << 20) | (s1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                if (v < 0 || v > 31) e.code = 2'd1;
            end else begin
                e.word = ((u & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                if (v < -2048 || v > 2047) e.code = 2'd1;
            end
            3'd4: begin
                e.word = (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                       | ((u & 32'h1F) << 7) | 32'h23;
                if (v < -2048 || v > 2047) e.code = 2'd1;
            end
            3'd5: begin
                e.word = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (s2 << 20)
                       | (s1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                       | (((u >> 11) & 1) << 7) | 32'h63;
                if (v < -4096 || v > 4094) e.code = 2'd1;
                else if (v % 2 != 0)       e.code = 2'd2;
            end
            3'd6: begin
                e.word = (u & 32'hFFFFF000) | (rd << 7) | 32'h37;
                if ((u & 32'hFFF) != 0) e.code = 2'd3;
            end
            default: begin
                e.word = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                       | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
                if (v < -1048576 || v > 1048574) e.code = 2'd1;
                else if (v % 2 != 0)             e.code = 2'd2;
            end
        endcase
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int k;
        r = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 32'h0, 1'b0);
        k = $urandom_range(0, 9);
        if (k == 0)      r.imm = $urandom();
        else if (k == 1) r.imm = edges[$urandom_range(0, 17)];
        else case (r.cls)
            3'd2: r.imm = (r.f3 == 3'd1 || r.f3 == 3'd5) ? $urandom_range(0, 31)
                                                         : $urandom_range(0, 4095) - 2048;
            3'd1, 3'd3, 3'd4: r.imm = $urandom_range(0, 4095) - 2048;
            3'd5: r.imm = 2 * $urandom_range(0, 4095) - 4096;
            3'd6: r.imm = $urandom() & 32'hFFFFF000;
            3'd7: r.imm = 2 * $urandom_range(0, 1048575) - 1048576;
            default: r.imm = $urandom();
        endcase
        return r;
    endfunction

    // Called at a negedge; holds valid until the DUT is ready, returns one
    // negedge after the handshake edge (i.e. inside the ENC cycle).
    task automatic send(input req_t r);
        bit ok = 0;
        req_valid = 1'b1; req_last = r.last; req_class = r.cls; req_funct3 = r.f3;
        req_f7b5 = r.f7b5; req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
        for (int i = 0; i < 16; i++) begin
            if (bus0.req_ready) begin ok = 1; @(negedge clk); break; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!ok) chk("req_accept_timeout", 32'(bus0.req_ready), 32'd1);
    endtask

    task automatic pulse_start();
        wq0.delete(); wq1.delete(); hs0.delete(); hs1.delete();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic run_sess(input bit wait_done);
        pulse_start();
        foreach (sess[i]) send(sess[i]);
        if (wait_done) begin
            for (int i = 0; i < 20; i++) begin
                if (done0) break;
                @(negedge clk);
            end
            chk("done", 32'(done0), 32'd1);
        end
    endtask

    task automatic chk_wr(input string nm, input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < wq0.size()) begin
            chk({nm, "_addr"}, wq0[i].addr, a);
            chk({nm, "_data"}, wq0[i].data, d);
        end
    endtask

    initial begin
        exp_t m;
        logic [31:0] exp_w[$];
        logic [1:0] ecode;
        int n;
        rst = 1'b1; start = 1'b0; req_valid = 1'b0; req_last = 1'b0; req_class = '0;
        req_funct3 = '0; req_f7b5 = 1'b0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus0.req_ready), 0); chk("rst_we", 32'(bus0.imem_we), 0);
        chk("rst_addr", bus0.imem_addr, 0);       chk("rst_wdata", bus0.imem_wdata, 0);
        chk("rst_count", 32'(count0), 0);         chk("rst_done", 32'(done0), 0);
        chk("rst_err", 32'(err0), 0);             chk("rst_code", 32'(code0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus0.req_ready), 0);

        // Single-request sessions against hand-computed words / error codes.
        tab.push_back('{mk(0,0,0,3,1,2,0,1),            32'h002081B3, 2'd0});
        tab.push_back('{mk(0,0,1,3,1,2,0,1),            32'h402081B3, 2'd0});
        tab.push_back('{mk(1,2,0,5,2,0,8,1),            32'h00812283, 2'd0});
        tab.push_back('{mk(4,2,0,0,2,5,12,1),           32'h00512623, 2'd0});
        tab.push_back('{mk(2,5,1,5,6,0,3,1),            32'h40335293, 2'd0});
        tab.push_back('{mk(5,0,0,0,1,2,-8,1),           32'hFE208CE3, 2'd0});
        tab.push_back('{mk(7,0,0,1,0,0,2048,1),         32'h001000EF, 2'd0});
        tab.push_back('{mk(6,0,0,5,0,0,32'h12345000,1), 32'h123452B7, 2'd0});
        tab.push_back('{mk(3,3,0,1,5,0,-4,1),           32'hFFC280E7, 2'd0});
        tab.push_back('{mk(5,0,0,0,0,0,4094,1),         32'h7E000FE3, 2'd0});
        tab.push_back('{mk(7,0,0,0,0,0,-1048576,1),     32'h8000006F, 2'd0});
        tab.push_back('{mk(2,0,0,1,0,0,-2048,1),        32'h80000093, 2'd0});
        tab.push_back('{mk(4,2,0,0,2,1,2047,1),         32'h7E112FA3, 2'd0});
        tab.push_back('{mk(5,0,0,0,1,2,6000,1),         32'h0, 2'd1});
        tab.push_back('{mk(7,0,0,1,0,0,3,1),            32'h0, 2'd2});
        tab.push_back('{mk(6,0,0,5,0,0,32'h12345001,1), 32'h0, 2'd3});
        tab.push_back('{mk(2,0,0,1,0,0,2048,1),         32'h0, 2'd1});
        tab.push_back('{mk(2,1,0,1,1,0,32,1),           32'h0, 2'd1});
        tab.push_back('{mk(2,1,0,1,1,0,-1,1),           32'h0, 2'd1});
        tab.push_back('{mk(5,0,0,0,0,0,4095,1),         32'h0, 2'd1});
        tab.push_back('{mk(5,0,0,0,0,0,3,1),            32'h0, 2'd2});
        tab.push_back('{mk(7,0,0,0,0,0,1048575,1),      32'h0, 2'd1});
        foreach (tab[i]) begin
            sess.delete(); sess.push_back(tab[i].r);
            run_sess(1);
            chk($sformatf("tab%0d_code", i), 32'(code0), 32'(tab[i].code));
            chk($sformatf("tab%0d_err", i), 32'(err0), 32'(tab[i].code != 0));
            chk($sformatf("tab%0d_nwr", i), wq0.size(), (tab[i].code == 0) ? 1 : 0);
            if (tab[i].code == 0) chk_wr($sformatf("tab%0d", i), 0, 32'h0, tab[i].word);
        end

        // Two-word session: addresses advance, write lands two cycles after handshake.
        sess.delete();
        sess.push_back(tab[0].r); sess[0].last = 1'b0; sess.push_back(tab[1].r);
        run_sess(1);
        chk("s1_count", 32'(count0), 2); chk("s1_nwr", wq0.size(), 2);
        chk_wr("s1_w0", 0, 32'h0, 32'h002081B3); chk_wr("s1_w1", 1, 32'h4, 32'h402081B3);
        for (int i = 0; i < 2 && i < wq0.size() && i < hs0.size(); i++)
            chk($sformatf("s1_lat%0d", i), wq0[i].cyc - hs0[i], 2);

        sess.delete();
        for (int i = 5; i < 8; i++) begin sess.push_back(tab[i].r); sess[i-5].last = (i == 7); end
        run_sess(1);
        chk("s2_count", 32'(count0), 3);
        chk_wr("s2_w0", 0, 32'h0, 32'hFE208CE3); chk_wr("s2_w1", 1, 32'h4, 32'h001000EF);
        chk_wr("s2_w2", 2, 32'h8, 32'h123452B7);

        // Good word then an illegal one: count stays at 1, no second write.
        sess.delete();
        sess.push_back(tab[2].r); sess[0].last = 1'b0; sess.push_back(tab[13].r);
        run_sess(1);
        chk("s3_count", 32'(count0), 1); chk("s3_nwr", wq0.size(), 1);
        chk("s3_err", 32'(err0), 1);     chk("s3_code", 32'(code0), 1);
        chk("s3_ready", 32'(bus0.req_ready), 0);

        // Five requests without last: DEPTH=4 instance stops after four writes.
        sess.delete();
        for (int i = 0; i < 5; i++) sess.push_back(mk(0, 0, 0, i + 1, 1, 2, 0, 0));
        run_sess(0);
        repeat (4) @(negedge clk);
        chk("d4_nwr", wq1.size(), 4); chk("d4_nhs", hs1.size(), 4);
        for (int i = 0; i < 4 && i < wq1.size(); i++) chk($sformatf("d4_addr%0d", i), wq1[i].addr, 32'(4 * i));
        chk("d4_count", 32'(count1), 4); chk("d4_done", 32'(done1), 1);
        chk("d4_ready", 32'(bus1.req_ready), 0); chk("d256_count", 32'(count0), 5);

        // start during ENC drops the word and rewinds the session.
        sess.delete(); sess.push_back(tab[0].r); sess[0].last = 1'b0;
        run_sess(0);
        repeat (2) @(negedge clk);
        chk("se_addr_pre", bus0.imem_addr, 32'h4);
        send(tab[3].r);                       // now in ENC
        wq0.delete();
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("se_ready", 32'(bus0.req_ready), 1); chk("se_addr", bus0.imem_addr, 0);
        chk("se_count", 32'(count0), 0);         chk("se_done", 32'(done0), 0);
        repeat (3) @(negedge clk);
        chk("se_nowrite", wq0.size(), 0);

        // rst during WRITE: everything back to zero next cycle.
        send(tab[1].r);                       // ENC; last flag is set, irrelevant here
        @(negedge clk);
        chk("rw_we", 32'(bus0.imem_we), 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("rw_ready", 32'(bus0.req_ready), 0); chk("rw_we0", 32'(bus0.imem_we), 0);
        chk("rw_addr", bus0.imem_addr, 0);       chk("rw_wdata", bus0.imem_wdata, 0);
        chk("rw_count", 32'(count0), 0);         chk("rw_done", 32'(done0), 0);
        chk("rw_err", 32'(err0), 0);             chk("rw_code", 32'(code0), 0);
        @(negedge clk);
        chk("rw_idle", 32'(bus0.req_ready), 0);

        // Randomized sessions against the reference model.
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(1, 6);
            sess.delete(); exp_w.delete(); ecode = 2'd0;
            for (int k = 0; k < n; k++) begin
                sess.push_back(rand_req());
                sess[k].last = (k == n - 1);
                m = model(sess[k]);
                if (m.code != 0) begin ecode = m.code; break; end
                exp_w.push_back(m.word);
            end
            run_sess(1);
            chk($sformatf("r%0d_nwr", s), wq0.size(), exp_w.size());
            chk($sformatf("r%0d_count", s), 32'(count0), exp_w.size());
            chk($sformatf("r%0d_code", s), 32'(code0), 32'(ecode));
            chk($sformatf("r%0d_err", s), 32'(err0), 32'(ecode != 0));
            foreach (exp_w[i]) chk_wr($sformatf("r%0d_w%0d", s, i), i, 32'(4 * i), exp_w[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rv32i_instr_encoder_loader.md
Name: rv32i_instr_encoder_loader

Overview:
Inverse of the core's main decoder. It takes a symbolic instruction request (instruction class, funct3, funct7[5], rd, rs1, rs2, 32-bit immediate), checks that the fields are legal, and packs them into a 32-bit RV32I instruction word. It writes each word sequentially into instruction memory through a one-cycle write port. Benches and the boot loader use it to build programs for the single-cycle and pipelined cores.

Parameters:
ADDR_W, 32, width of the imem byte address
BASE_ADDR, 32'h0, first byte address written after start
DEPTH, 256, maximum words per load session

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; opens a new load session
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_last  in  1  marks the final request of the session
req_class  in  3  0=R, 1=LOAD, 2=I-ALU, 3=JALR, 4=STORE, 5=BRANCH, 6=LUI, 7=JAL
req_funct3  in  3  funct3 field
req_f7b5  in  1  funct7[5] (SUB/SRA/SRAI)
req_rd, req_rs1, req_rs2  in  5 each  register indices
req_imm  in  32  signed immediate, byte offset for branches and jumps
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  byte address, word aligned
imem_wdata  out  32  encoded instruction
count  out  $clog2(DEPTH)+1  words written this session
done  out  1  session complete (level)
err  out  1  sticky illegal-request flag
err_code  out  2  0=none, 1=imm range, 2=imm alignment, 3=LUI low bits nonzero

Behaviour:
- Reset: state IDLE. All outputs 0, including req_ready, imem_we, imem_addr, imem_wdata, count, done, err and err_code.
- FSM states: IDLE, WAIT, ENC, WRITE, DONE.
- start, in any state, takes priority over everything else:
  - next state WAIT
  - imem_addr = BASE_ADDR, count = 0
  - done, err and err_code cleared
  - any in-flight word is dropped, with no write
- WAIT:
  - req_ready = 1.
  - On handshake, latch all req_* fields and go to ENC.
- ENC:
  - Register the encoded word and the check result into imem_wdata and err_code.
  - If the check fails: err = 1, go to DONE. No write occurs and count is unchanged.
  - Otherwise go to WRITE.
- WRITE:
  - imem_we = 1 for exactly this one cycle, with imem_addr and imem_wdata stable.
  - Next cycle: imem_addr += 4 and count += 1.
  - If the latched last flag is set, or the new count == DEPTH, go to DONE; otherwise return to WAIT.
- Timing: a handshake in cycle T produces imem_we in cycle T+2. Peak throughput is 1 word per 3 cycles.
- DONE: done = 1 and req_ready = 0. The block stays here until start or rst.
- IDLE: req_ready = 0 and done = 0.
- Encodings (opc = opcode):
  - R: {0,f7b5,00000, rs2, rs1, f3, rd, 0110011}
  - LOAD: {imm[11:0], rs1, f3, rd, 0000011}
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}. When f3 = 001 or 101, bits[31:25] = {0,f7b5,00000} and bits[24:20] = imm[4:0].
  - JALR: {imm[11:0], rs1, 000, rd, 1100111}
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}
  - LUI: {imm[31:12], rd, 0110111}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
- Immediate checks, all on the signed 32-bit value; error code in brackets:
  - LOAD, I-ALU (non-shift), JALR, STORE: imm must lie in [-2048, 2047] (1).
  - Shifts: imm must lie in [0, 31] (1).
  - BRANCH: imm must lie in [-4096, 4094] (1) and imm[0] must be 0 (2).
  - JAL: imm must lie in [-2^20, 2^20-2] (1) and imm[0] must be 0 (2).
  - LUI: imm[11:0] must be 0 (3).
  - R-type: never errors.
  - When range and alignment both fail, range wins.
- req_valid outside WAIT is ignored; requests are never buffered.
- rst mid-session returns the block to IDLE with all outputs 0.

Test Plan:
- start; R add x3,x1,x2 (f3=0, f7b5=0), last=0; then f7b5=1 (sub), last=1 -> two writes: addr 0x0 = 0x002081B3, addr 0x4 = 0x402081B3; count=2, done=1, each imem_we exactly 2 cycles after its handshake.
- LOAD lw x5,8(x2); STORE sw x5,12(x2); I-ALU srai x5,x6,3 (f3=101, f7b5=1) -> 0x00812283, 0x00512623, 0x40335293 at consecutive addresses.
- BRANCH beq x1,x2,-8; JAL x1,2048; LUI x5, imm=0x12345000 -> 0xFE208CE3, 0x001000EF, 0x123452B7.
- Errors: BRANCH imm=6000 -> err=1, err_code=1, no imem_we, done=1, count unchanged. Then start, and JAL imm=3 -> err_code=2. LUI imm=0x12345001 -> err_code=3.
- DEPTH=4 build: 5 requests with last=0 -> 4 writes (0x0 to 0xC), done after the 4th write, req_ready=0, and the 5th request is never accepted.
- start pulsed during ENC -> no write for the dropped word, addr back to BASE_ADDR, count=0. Next, rst asserted during WRITE -> all outputs 0 the following cycle, state IDLE.
